// File: rtl/oversampler_phase_scanner.sv
// ---------------------------------------------------------------------------
// oversampler_phase_scanner
//
// Selects the sample phase of a manually steered oversampler. A start pulse
// scans all four phases. Each phase gets a settle period and then an
// error-count window. The phase with the fewest phase_err assertions wins.
// The winner is locked only if its count is within ERR_THRESH. While locked,
// error windows keep running and their counts are reported.
//
// Optional feature (macro OVERSAMPLER_AUTO_RELOCK_EN):
//   defined   - a locked window whose count exceeds ERR_THRESH triggers an
//               automatic rescan and bumps relock_cnt (saturating).
//   undefined - locked windows are only reported; relock_cnt stays 0.
//
// Ports:
//   clock, reset    rising-edge clock, asynchronous active-high reset
//   start           single-cycle scan request (ignored while busy)
//   phase_err       oversampler error flag, synchronous to clock
//   phase_sel       phase select to the oversampler
//   busy            scan in progress
//   locked          a qualified phase is selected
//   lock_fail       last scan found no qualifying phase (sticky)
//   best_err_cnt    lowest window count found by the last scan
//   window_err_cnt  count of the last completed window while locked
//   relock_cnt      automatic rescans since reset
// ---------------------------------------------------------------------------
module oversampler_phase_scanner #(
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned WINDOW_BITS   = 10,
  parameter int unsigned ERR_THRESH    = 16,
  parameter int unsigned CNT_BITS      = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  phase_err,
  output logic [1:0]            phase_sel,
  output logic                  busy,
  output logic                  locked,
  output logic                  lock_fail,
  output logic [WINDOW_BITS:0]  best_err_cnt,
  output logic [WINDOW_BITS:0]  window_err_cnt,
  output logic [CNT_BITS-1:0]   relock_cnt
);

  localparam int unsigned CW = WINDOW_BITS + 1;
  // One timer serves both the settle period and the error window.
  localparam int unsigned TW = (WINDOW_BITS > 8) ? WINDOW_BITS : 8;
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] WINDOW_LAST = TW'((1 << WINDOW_BITS) - 1);
  localparam logic [CW-1:0] THRESH      = CW'(ERR_THRESH);

`ifdef OVERSAMPLER_AUTO_RELOCK_EN
  localparam bit RELOCK_EN = 1'b1;
`else
  localparam bit RELOCK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_COUNT, S_EVAL, S_DECIDE, S_LOCKED
  } state_e;

  state_e              state_q, state_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [CW-1:0]       err_cnt_q, err_cnt_d;
  logic [CW-1:0]       best_err_q, best_err_d;
  logic [1:0]          best_phase_q, best_phase_d;
  logic [1:0]          phase_sel_q, phase_sel_d;
  logic                busy_q, busy_d;
  logic                locked_q, locked_d;
  logic                lock_fail_q, lock_fail_d;
  logic [CW-1:0]       best_err_cnt_q, best_err_cnt_d;
  logic [CW-1:0]       window_err_cnt_q, window_err_cnt_d;
  logic [CNT_BITS-1:0] relock_cnt_q, relock_cnt_d;

  logic [CW-1:0]       err_inc;
  logic                begin_scan;

  always_comb begin
    state_d          = state_q;
    tmr_d            = tmr_q;
    err_cnt_d        = err_cnt_q;
    best_err_d       = best_err_q;
    best_phase_d     = best_phase_q;
    phase_sel_d      = phase_sel_q;
    busy_d           = busy_q;
    locked_d         = locked_q;
    lock_fail_d      = lock_fail_q;
    best_err_cnt_d   = best_err_cnt_q;
    window_err_cnt_d = window_err_cnt_q;
    relock_cnt_d     = relock_cnt_q;
    begin_scan       = 1'b0;
    // Includes the current cycle's sample, so window ends see the last bit.
    err_inc          = err_cnt_q + CW'(phase_err);

    case (state_q)
      S_IDLE: begin
        if (start) begin_scan = 1'b1;
      end
      S_SETTLE: begin
        if (tmr_q == SETTLE_LAST) begin
          state_d   = S_COUNT;
          tmr_d     = '0;
          err_cnt_d = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_COUNT: begin
        err_cnt_d = err_inc;
        if (tmr_q == WINDOW_LAST) state_d = S_EVAL;
        else                      tmr_d   = tmr_q + TW'(1);
      end
      S_EVAL: begin
        // Strict compare: on ties the earlier (lower) phase is kept.
        if (err_cnt_q < best_err_q) begin
          best_err_d   = err_cnt_q;
          best_phase_d = phase_sel_q;
        end
        if (phase_sel_q == 2'd3) begin
          state_d = S_DECIDE;
        end else begin
          phase_sel_d = phase_sel_q + 2'd1;
          state_d     = S_SETTLE;
          tmr_d       = '0;
        end
      end
      S_DECIDE: begin
        best_err_cnt_d = best_err_q;
        busy_d         = 1'b0;
        if (best_err_q <= THRESH) begin
          phase_sel_d = best_phase_q;
          locked_d    = 1'b1;
          state_d     = S_LOCKED;
          tmr_d       = '0;
          err_cnt_d   = '0;
        end else begin
          lock_fail_d = 1'b1;
          phase_sel_d = 2'd0;
          state_d     = S_IDLE;
        end
      end
      S_LOCKED: begin
        if (tmr_q == WINDOW_LAST) begin
          window_err_cnt_d = err_inc;
          err_cnt_d        = '0;
          tmr_d            = '0;
          // An explicit start takes precedence and is not counted as a relock.
          if (RELOCK_EN && !start && (err_inc > THRESH)) begin
            begin_scan = 1'b1;
            if (relock_cnt_q != '1) relock_cnt_d = relock_cnt_q + CNT_BITS'(1);
          end
        end else begin
          err_cnt_d = err_inc;
          tmr_d     = tmr_q + TW'(1);
        end
        if (start) begin_scan = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (begin_scan) begin
      state_d      = S_SETTLE;
      phase_sel_d  = 2'd0;
      busy_d       = 1'b1;
      locked_d     = 1'b0;
      lock_fail_d  = 1'b0;
      best_err_d   = '1;
      best_phase_d = 2'd0;
      tmr_d        = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      tmr_q            <= '0;
      err_cnt_q        <= '0;
      best_err_q       <= '1;
      best_phase_q     <= 2'd0;
      phase_sel_q      <= 2'd0;
      busy_q           <= 1'b0;
      locked_q         <= 1'b0;
      lock_fail_q      <= 1'b0;
      best_err_cnt_q   <= '0;
      window_err_cnt_q <= '0;
      relock_cnt_q     <= '0;
    end else begin
      state_q          <= state_d;
      tmr_q            <= tmr_d;
      err_cnt_q        <= err_cnt_d;
      best_err_q       <= best_err_d;
      best_phase_q     <= best_phase_d;
      phase_sel_q      <= phase_sel_d;
      busy_q           <= busy_d;
      locked_q         <= locked_d;
      lock_fail_q      <= lock_fail_d;
      best_err_cnt_q   <= best_err_cnt_d;
      window_err_cnt_q <= window_err_cnt_d;
      relock_cnt_q     <= relock_cnt_d;
    end
  end

  assign phase_sel      = phase_sel_q;
  assign busy           = busy_q;
  assign locked         = locked_q;
  assign lock_fail      = lock_fail_q;
  assign best_err_cnt   = best_err_cnt_q;
  assign window_err_cnt = window_err_cnt_q;
  assign relock_cnt     = relock_cnt_q;

endmodule

// File: tb/tb_oversampler_phase_scanner.sv
// ---------------------------------------------------------------------------
// Testbench for oversampler_phase_scanner (SETTLE_CYCLES=2, WINDOW_BITS=4,
// ERR_THRESH=2). Each scan is driven from a per-edge phase_err array indexed
// from the start edge; phase k's error window covers edges 19k+3 .. 19k+18
// and the decision is visible after edge 77.
// ---------------------------------------------------------------------------
module tb_oversampler_phase_scanner;

  localparam int unsigned SC = 2;
  localparam int unsigned WB = 4;
  localparam int unsigned ET = 2;
  localparam int unsigned CB = 8;
  localparam int SCAN = 77;
  localparam int PH   = 19;

`ifdef OVERSAMPLER_AUTO_RELOCK_EN
  localparam bit RELOCK = 1'b1;
`else
  localparam bit RELOCK = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          phase_err;
  logic [1:0]    phase_sel;
  logic          busy;
  logic          locked;
  logic          lock_fail;
  logic [WB:0]   best_err_cnt;
  logic [WB:0]   window_err_cnt;
  logic [CB-1:0] relock_cnt;

  always #5 clock = ~clock;

  oversampler_phase_scanner #(
    .SETTLE_CYCLES(SC),
    .WINDOW_BITS  (WB),
    .ERR_THRESH   (ET),
    .CNT_BITS     (CB)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .phase_err     (phase_err),
    .phase_sel     (phase_sel),
    .busy          (busy),
    .locked        (locked),
    .lock_fail     (lock_fail),
    .best_err_cnt  (best_err_cnt),
    .window_err_cnt(window_err_cnt),
    .relock_cnt    (relock_cnt)
  );

  typedef struct {
    string name;
    int    c0, c1, c2, c3;
    bit    lk;
    int    ph;
    int    best;
  } vec_t;

  int    checks = 0;
  int    failures = 0;
  string cur = "init";
  bit    pe_arr [0:SCAN-1];
  bit    win_arr[0:15];
  int    exp_relock = 0;
  int    exp_phase = 0;
  vec_t  vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s/%s: got %0d expected %0d", cur, name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Error pulses at the start of each phase's window; phase_err held high in
  // every cycle where it must be ignored (settle, eval, decide, start edge).
  task automatic fill_counts(input int c0, input int c1, input int c2, input int c3);
    int c[4];
    c = '{c0, c1, c2, c3};
    for (int i = 0; i < SCAN; i++) begin
      int k, o;
      k = i / PH;
      o = i % PH;
      if (k < 4 && o >= 3 && o <= 18) pe_arr[i] = ((o - 3) < c[k]);
      else                            pe_arr[i] = 1'b1;
    end
  endtask

  task automatic model_scan(output bit lk, output int ph, output int best);
    best = 1000;
    ph   = 0;
    for (int k = 0; k < 4; k++) begin
      int n;
      n = 0;
      for (int j = 0; j < 16; j++) n += int'(pe_arr[PH*k + 3 + j]);
      if (n < best) begin
        best = n;
        ph   = k;
      end
    end
    lk = (best <= int'(ET));
    if (!lk) ph = 0;
  endtask

  task automatic do_scan(input bit already_started, input int spur_at,
                         input bit exp_lk, input int exp_ph, input int exp_best);
    if (!already_started) begin
      start = 1'b1;
      phase_err = pe_arr[0];
      tick();
      start = 1'b0;
      chk("entry_busy", busy, 1);
      chk("entry_locked", locked, 0);
      chk("entry_lock_fail", lock_fail, 0);
      chk("entry_phase", phase_sel, 0);
    end
    for (int i = 1; i < SCAN; i++) begin
      phase_err = pe_arr[i];
      start = (i == spur_at);
      tick();
      start = 1'b0;
      if (i % PH == 10 && i < 76) begin
        chk("mid_phase", phase_sel, i / PH);
        chk("mid_busy", busy, 1);
      end
    end
    chk("pre_decide_busy", busy, 1);
    chk("pre_decide_locked", locked, 0);
    phase_err = 1'b0;
    tick();
    chk("busy", busy, 0);
    chk("locked", locked, exp_lk);
    chk("lock_fail", lock_fail, !exp_lk);
    chk("phase_sel", phase_sel, exp_lk ? exp_ph : 0);
    chk("best_err_cnt", best_err_cnt, exp_best);
    chk("relock_cnt", relock_cnt, exp_relock);
    exp_phase = exp_lk ? exp_ph : 0;
  endtask

  task automatic run_window(input bit start_end, output bit scanning);
    int n;
    n = 0;
    for (int j = 0; j < 16; j++) begin
      phase_err = win_arr[j];
      n += int'(win_arr[j]);
      start = start_end && (j == 15);
      tick();
      start = 1'b0;
    end
    chk("win_cnt", window_err_cnt, n);
    scanning = start_end || (RELOCK && n > int'(ET));
    if (!start_end && scanning && exp_relock < 255) exp_relock++;
    chk("win_locked", locked, !scanning);
    chk("win_busy", busy, scanning);
    chk("win_phase", phase_sel, scanning ? 0 : exp_phase);
    chk("win_relock", relock_cnt, exp_relock);
  endtask

  task automatic set_win(input int n);
    for (int j = 0; j < 16; j++) win_arr[j] = (j < n);
  endtask

  initial begin
    bit lk;
    int ph, best;
    bit scanning;
    int plist[4];
    int p[4];

    plist = '{0, 5, 30, 100};
    vecs[0] = '{"ph2_clean",   16, 16, 0, 16, 1'b1, 2, 0};
    vecs[1] = '{"all_bad",     16, 16, 16, 16, 1'b0, 0, 16};
    vecs[2] = '{"all_clean",    0, 0, 0, 0, 1'b1, 0, 0};
    vecs[3] = '{"tie_at_thr",   3, 2, 2, 5, 1'b1, 1, 2};
    vecs[4] = '{"over_thr",     3, 3, 4, 3, 1'b0, 0, 3};
    vecs[5] = '{"last_best",    9, 5, 4, 1, 1'b1, 3, 1};

    reset = 1'b1;
    start = 1'b0;
    phase_err = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    cur = "reset";
    chk("phase_sel", phase_sel, 0);
    chk("busy", busy, 0);
    chk("locked", locked, 0);
    chk("lock_fail", lock_fail, 0);
    chk("best_err_cnt", best_err_cnt, 0);
    chk("window_err_cnt", window_err_cnt, 0);
    chk("relock_cnt", relock_cnt, 0);
    reset = 1'b0;
    tick();

    // Table-driven scans.
    foreach (vecs[v]) begin
      cur = vecs[v].name;
      fill_counts(vecs[v].c0, vecs[v].c1, vecs[v].c2, vecs[v].c3);
      do_scan(1'b0, -1, vecs[v].lk, vecs[v].ph, vecs[v].best);
      if (!vecs[v].lk) begin
        repeat (3) tick();
        chk("sticky_fail", lock_fail, 1);
        chk("idle_busy", busy, 0);
      end
    end

    // Randomized scans against the model.
    for (int r = 0; r < 8; r++) begin
      cur = $sformatf("rand_scan%0d", r);
      for (int k = 0; k < 4; k++) p[k] = plist[$urandom_range(0, 3)];
      for (int i = 0; i < SCAN; i++)
        pe_arr[i] = ($urandom_range(0, 99) < p[(i / PH > 3) ? 3 : i / PH]);
      model_scan(lk, ph, best);
      do_scan(1'b0, -1, lk, ph, best);
    end

    // Locked monitoring.
    cur = "monitor";
    fill_counts(16, 16, 0, 16);
    do_scan(1'b0, -1, 1'b1, 2, 0);
    set_win(0);
    run_window(1'b0, scanning);
    set_win(2);
    run_window(1'b0, scanning);
    set_win(3);
    run_window(1'b0, scanning);
    if (scanning) begin
      cur = "relock_scan";
      do_scan(1'b1, -1, 1'b1, 2, 0);
    end
    cur = "start_at_win_end";
    set_win(3);
    run_window(1'b1, scanning);
    fill_counts(16, 0, 16, 16);
    do_scan(1'b1, -1, 1'b1, 1, 0);
    for (int w = 0; w < 8; w++) begin
      cur = $sformatf("rand_win%0d", w);
      for (int j = 0; j < 16; j++) win_arr[j] = ($urandom_range(0, 99) < 15);
      run_window(1'b0, scanning);
      if (scanning) do_scan(1'b1, -1, 1'b1, 1, 0);
    end

    // Start while busy is ignored.
    cur = "spur_start";
    fill_counts(0, 16, 16, 16);
    do_scan(1'b0, 40, 1'b1, 0, 0);

    // Lock with a nonzero best count, then reset mid-COUNT of phase 2.
    cur = "pre_reset";
    fill_counts(5, 1, 16, 16);
    do_scan(1'b0, -1, 1'b1, 1, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (44) begin
      phase_err = $urandom_range(0, 1);
      tick();
    end
    cur = "mid_reset";
    chk("phase_before", phase_sel, 2);
    chk("busy_before", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    exp_relock = 0;
    chk("phase_sel", phase_sel, 0);
    chk("busy", busy, 0);
    chk("locked", locked, 0);
    chk("best_err_cnt", best_err_cnt, 0);
    chk("window_err_cnt", window_err_cnt, 0);
    chk("relock_cnt", relock_cnt, 0);
    @(posedge clock);
    #2;
    reset = 1'b0;
    repeat (20) begin
      phase_err = $urandom_range(0, 1);
      tick();
    end
    cur = "post_reset";
    chk("busy", busy, 0);
    chk("locked", locked, 0);
    chk("phase_sel", phase_sel, 0);
    fill_counts(0, 0, 0, 0);
    do_scan(1'b0, -1, 1'b1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/oversampler_phase_scanner.md
Name: oversampler_phase_scanner

Overview:
Controls an oversampler instantiated with PHASE_SEL_MANUAL=1. It drives that oversampler's phase_sel_in input. On a start pulse it scans all four sample phases. For each phase it counts phase_err assertions over a fixed window, then selects the phase with the fewest errors. It monitors the selected phase while locked and, optionally, rescans when errors exceed a threshold. One instance sits per trigger input pair, in the clock domain.

Parameters:
SETTLE_CYCLES, 8, clocks ignored after every phase_sel change (range 1..255)
WINDOW_BITS, 10, error-count window = 2^WINDOW_BITS clocks
ERR_THRESH, 16, maximum error count per window that still qualifies a phase (compare is <=)
CNT_BITS, 8, width of relock_cnt

Ports:
clock  in  1  logic clock; all state advances on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
start  in  1  single-cycle pulse; starts a scan from IDLE or LOCKED, ignored while busy
phase_err  in  1  oversampler phase_err, already synchronous to clock
phase_sel  out  2  to oversampler phase_sel_in
busy  out  1  scan in progress
locked  out  1  a phase is selected and qualified
lock_fail  out  1  last scan found no qualifying phase; sticky until next start or reset
best_err_cnt  out  WINDOW_BITS+1  lowest window count found by the last scan
window_err_cnt  out  WINDOW_BITS+1  count from the last completed monitor window in LOCKED
relock_cnt  out  CNT_BITS  automatic rescans since reset, saturating at all-ones

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, phase_sel=0, busy=0, locked=0, lock_fail=0, all counts 0.
- Error counter width is WINDOW_BITS+1. Its maximum possible value, 2^WINDOW_BITS, fits, so it never wraps.
- States: IDLE, SETTLE, COUNT, EVAL, DECIDE, LOCKED.
- IDLE, start=1:
  - next cycle enter SETTLE with phase_sel=0, busy=1, locked=0, lock_fail=0.
  - best_err = all-ones (internal), best_phase = 0, window counter = 0.
- SETTLE:
  - stay exactly SETTLE_CYCLES cycles; phase_err is ignored.
  - then go to COUNT with err_cnt=0.
- COUNT:
  - stay exactly 2^WINDOW_BITS cycles.
  - err_cnt increments on every cycle with phase_err=1, including the last cycle.
  - then go to EVAL.
- EVAL (1 cycle):
  - if err_cnt < best_err (strict), set best_err=err_cnt and best_phase=phase_sel. Ties keep the lower phase.
  - if phase_sel=3, go to DECIDE; otherwise phase_sel+1 and go to SETTLE.
- DECIDE (1 cycle): best_err_cnt <= best_err, busy=0.
  - if best_err <= ERR_THRESH: phase_sel=best_phase, locked=1, go to LOCKED.
  - otherwise: lock_fail=1, phase_sel=0, go to IDLE.
- Scan latency: the DECIDE outputs appear 4*(SETTLE_CYCLES+2^WINDOW_BITS+1)+1 clocks after the start cycle.
- LOCKED:
  - free-running windows of 2^WINDOW_BITS cycles, the first beginning the cycle after DECIDE.
  - at each window end, window_err_cnt <= count, including the final cycle's sample.
  - if count > ERR_THRESH and relock is enabled: locked=0, relock_cnt+1 (saturating), then run a full scan exactly as if from start.
- start in LOCKED: locked=0 and a scan begins; relock_cnt is unchanged.
- start coinciding with a window end in LOCKED: start wins. window_err_cnt still updates; relock_cnt does not increment.
- start while busy: ignored; the scan in progress continues undisturbed.
- phase_sel changes only on EVAL, DECIDE, or scan entry. It is stable during SETTLE, COUNT and LOCKED.
- reset asserted mid-scan or while LOCKED: all outputs return to reset values asynchronously. No scan begins until a new start.

Optional Feature:
Macro OVERSAMPLER_AUTO_RELOCK_EN.
- Defined: LOCKED performs the automatic rescan on threshold violation, as above.
- Undefined: LOCKED keeps counting and keeps updating window_err_cnt, but never leaves LOCKED except on start or reset. relock_cnt is held at 0.

Test Plan:
Bench parameters: SETTLE_CYCLES=2, WINDOW_BITS=4, ERR_THRESH=2. Scan length = 4*(2+16+1)+1 = 77 cycles.
1. phase_err=1 whenever phase_sel!=2, 0 when phase_sel=2, start pulse -> 77 clocks later locked=1, phase_sel=2, best_err_cnt=0, busy=0, lock_fail=0.
2. phase_err held 1, start -> 77 clocks later lock_fail=1, locked=0, phase_sel=0, best_err_cnt=16; a further start clears lock_fail on the next cycle.
3. phase_err held 0, start -> locked with phase_sel=0 (tie keeps lowest phase), best_err_cnt=0.
4. Locked, then 3 phase_err pulses in one window, macro defined -> window_err_cnt=3, locked drops, relock_cnt=1, busy=1. Macro undefined -> window_err_cnt=3, locked stays 1, relock_cnt=0.
5. reset pulse while phase_sel=2 mid-COUNT -> immediately phase_sel=0, busy=0, locked=0, all counts 0; start during busy scan -> no restart, lock at the original 77-cycle point.
6. In LOCKED, start on the same cycle as a violating window end (macro defined) -> relock_cnt unchanged, window_err_cnt updated, scan restarts from phase 0.
